// File: rtl/prediction_collector_pkg.sv
// Shared predictor definitions.
//   N_ENTRIES / IDX_W / CTR_W : default predictor geometry
//   CTR_WEAK_NT               : counter value reported for entries never updated
//   sat_next()                : saturating up/down step of a counter of a given width
package prediction_collector_pkg;

    localparam int unsigned N_ENTRIES = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CTR_W     = 2;

    // Widest counter the helper function supports; narrower counters are zero-extended.
    localparam int unsigned MAX_CTR_W = 8;

    localparam logic [CTR_W-1:0] CTR_WEAK_NT = 2'b01;

    // Saturating step: taken counts up to all-ones of 'width', not-taken counts down to zero.
    function automatic logic [MAX_CTR_W-1:0] sat_next(input logic [MAX_CTR_W-1:0] ctr,
                                                       input logic                 taken,
                                                       input int unsigned          width);
        logic [MAX_CTR_W-1:0] max_val;
        logic [MAX_CTR_W-1:0] result;
        max_val = (MAX_CTR_W'(1) << width) - MAX_CTR_W'(1);
        result  = ctr;
        if (taken) begin
            if (ctr != max_val) result = ctr + MAX_CTR_W'(1);
        end else begin
            if (ctr != '0) result = ctr - MAX_CTR_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/prediction_collector_sat_counter_next.sv
// sat_counter_next: combinational saturated next value of one predictor counter.
//   ctr_i   : current counter value
//   taken_i : resolved outcome, 1 = taken
//   ctr_o   : counter after one saturating step
module sat_counter_next
    import prediction_collector_pkg::*;
#(
    parameter int unsigned CTR_W = prediction_collector_pkg::CTR_W
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_o
);

    logic [MAX_CTR_W-1:0] ctr_ext;
    logic [MAX_CTR_W-1:0] next_ext;

    always_comb begin
        ctr_ext  = MAX_CTR_W'(ctr_i);
        next_ext = sat_next(ctr_ext, taken_i, CTR_W);
        ctr_o    = next_ext[CTR_W-1:0];
    end

endmodule

// File: rtl/prediction_collector.sv
// prediction_collector: registers a branch prediction read from a table of saturating counters.
//   CLK, RESET              : rising-edge clock, asynchronous active-high reset
//   READ_EN, column         : read request and entry to read
//   PRED_STATE              : packed counters of all entries, entry i at [i*CTR_W +: CTR_W]
//   UPD_ENABLE/COLUMN/OUTCOME : update strobe, entry and outcome happening this cycle
//   STALL                   : hold all outputs, ignore READ_EN
//   PREDICTION, PRED_CTR    : taken bit (counter MSB) and effective counter of the last read
//   PRED_COLUMN, VALID      : entry of the last read, outputs carry a fresh read
module prediction_collector
#(
    parameter int unsigned N_ENTRIES = prediction_collector_pkg::N_ENTRIES,
    parameter int unsigned IDX_W     = prediction_collector_pkg::IDX_W,
    parameter int unsigned CTR_W     = prediction_collector_pkg::CTR_W
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       READ_EN,
    input  logic [IDX_W-1:0]           column,
    input  logic [N_ENTRIES*CTR_W-1:0] PRED_STATE,
    input  logic                       UPD_ENABLE,
    input  logic [IDX_W-1:0]           UPD_COLUMN,
    input  logic                       UPD_OUTCOME,
    input  logic                       STALL,
    output logic                       PREDICTION,
    output logic [CTR_W-1:0]           PRED_CTR,
    output logic [IDX_W-1:0]           PRED_COLUMN,
    output logic                       VALID
);

    import prediction_collector_pkg::*;

    localparam logic [CTR_W-1:0] WeakNt = CTR_W'(CTR_WEAK_NT);

    logic [N_ENTRIES-1:0] seen_q;
    logic [CTR_W-1:0]     ctr_q;
    logic [IDX_W-1:0]     col_q;
    logic                 valid_q;

    logic [CTR_W-1:0]     entry_ctr;
    logic [CTR_W-1:0]     fwd_ctr;
    logic [CTR_W-1:0]     eff_ctr;

    always_comb begin
        entry_ctr = PRED_STATE[int'(column)*CTR_W +: CTR_W];
    end

    sat_counter_next #(
        .CTR_W(CTR_W)
    ) u_sat_counter_next (
        .ctr_i  (entry_ctr),
        .taken_i(UPD_OUTCOME),
        .ctr_o  (fwd_ctr)
    );

    // A same-cycle update to the read entry wins; PRED_STATE does not reflect it yet.
    // Entries never updated since reset report weakly-not-taken regardless of PRED_STATE.
    always_comb begin
        eff_ctr = WeakNt;
        if (UPD_ENABLE && (UPD_COLUMN == column)) begin
            eff_ctr = fwd_ctr;
        end else if (seen_q[column]) begin
            eff_ctr = entry_ctr;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            seen_q  <= '0;
            ctr_q   <= WeakNt;
            col_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // Updates are tracked even while stalled.
            if (UPD_ENABLE) begin
                seen_q[UPD_COLUMN] <= 1'b1;
            end
            if (!STALL) begin
                if (READ_EN) begin
                    ctr_q   <= eff_ctr;
                    col_q   <= column;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign PREDICTION  = ctr_q[CTR_W-1];
    assign PRED_CTR    = ctr_q;
    assign PRED_COLUMN = col_q;
    assign VALID       = valid_q;

endmodule

// File: tb/tb_prediction_collector.sv
// Directed self-checking bench for prediction_collector.
module tb_prediction_collector;

    logic        CLK;
    logic        RESET;
    logic        READ_EN;
    logic [3:0]  column;
    logic [31:0] PRED_STATE;
    logic        UPD_ENABLE;
    logic [3:0]  UPD_COLUMN;
    logic        UPD_OUTCOME;
    logic        STALL;
    logic        PREDICTION;
    logic [1:0]  PRED_CTR;
    logic [3:0]  PRED_COLUMN;
    logic        VALID;

    int checks;
    int errors;

    prediction_collector #(
        .N_ENTRIES(16),
        .IDX_W    (4),
        .CTR_W    (2)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ_EN    (READ_EN),
        .column     (column),
        .PRED_STATE (PRED_STATE),
        .UPD_ENABLE (UPD_ENABLE),
        .UPD_COLUMN (UPD_COLUMN),
        .UPD_OUTCOME(UPD_OUTCOME),
        .STALL      (STALL),
        .PREDICTION (PREDICTION),
        .PRED_CTR   (PRED_CTR),
        .PRED_COLUMN(PRED_COLUMN),
        .VALID      (VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic pred, input logic [1:0] ctr,
                             input logic [3:0] col, input logic vld);
        check({tag, ".PREDICTION"},  32'(PREDICTION),  32'(pred));
        check({tag, ".PRED_CTR"},    32'(PRED_CTR),    32'(ctr));
        check({tag, ".PRED_COLUMN"}, 32'(PRED_COLUMN), 32'(col));
        check({tag, ".VALID"},       32'(VALID),       32'(vld));
    endtask

    task automatic set_entry(input int idx, input logic [1:0] val);
        PRED_STATE[idx*2 +: 2] = val;
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic read(input logic [3:0] col);
        READ_EN = 1'b1;
        column  = col;
    endtask

    task automatic update(input logic en, input logic [3:0] col, input logic taken);
        UPD_ENABLE  = en;
        UPD_COLUMN  = col;
        UPD_OUTCOME = taken;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        RESET       = 1'b1;
        READ_EN     = 1'b0;
        column      = '0;
        PRED_STATE  = '0;
        UPD_ENABLE  = 1'b0;
        UPD_COLUMN  = '0;
        UPD_OUTCOME = 1'b0;
        STALL       = 1'b0;

        #3;
        check_out("reset", 1'b0, 2'b01, 4'd0, 1'b0);
        step();
        RESET = 1'b0;

        // Unseen entry reports weakly-not-taken even though PRED_STATE says strongly taken.
        set_entry(5, 2'b11);
        read(4'd5);
        step();
        check_out("unseen5", 1'b0, 2'b01, 4'd5, 1'b1);

        // VALID drops after one cycle, other outputs hold.
        READ_EN = 1'b0;
        step();
        check_out("valid_drop", 1'b0, 2'b01, 4'd5, 1'b0);

        // Forwarding from an unseen entry: 01 taken -> 10.
        set_entry(3, 2'b01);
        update(1'b1, 4'd3, 1'b1);
        read(4'd3);
        step();
        check_out("fwd3", 1'b1, 2'b10, 4'd3, 1'b1);

        // Saturation at top and bottom.
        set_entry(15, 2'b11);
        update(1'b1, 4'd15, 1'b1);
        read(4'd15);
        step();
        check_out("sat_top", 1'b1, 2'b11, 4'd15, 1'b1);

        set_entry(0, 2'b00);
        update(1'b1, 4'd0, 1'b0);
        read(4'd0);
        step();
        check_out("sat_bot", 1'b0, 2'b00, 4'd0, 1'b1);

        // Entry 3 is now seen: plain read returns PRED_STATE.
        update(1'b0, 4'd0, 1'b0);
        set_entry(3, 2'b10);
        read(4'd3);
        step();
        check_out("seen3", 1'b1, 2'b10, 4'd3, 1'b1);

        // Not-taken forward on a seen entry: 10 -> 01.
        update(1'b1, 4'd3, 1'b0);
        read(4'd3);
        step();
        check_out("fwd3_nt", 1'b0, 2'b01, 4'd3, 1'b1);

        // Update to another entry does not forward; entry 9 is unseen.
        set_entry(4, 2'b00);
        set_entry(9, 2'b10);
        update(1'b1, 4'd4, 1'b1);
        read(4'd9);
        step();
        check_out("no_fwd9", 1'b0, 2'b01, 4'd9, 1'b1);
        update(1'b0, 4'd0, 1'b0);
        read(4'd4);
        step();
        check_out("seen4", 1'b0, 2'b00, 4'd4, 1'b1);

        // Stall: known outputs from unseen entry 2, then stall two cycles while reading/updating 7.
        set_entry(2, 2'b11);
        read(4'd2);
        step();
        check_out("pre_stall", 1'b0, 2'b01, 4'd2, 1'b1);
        set_entry(7, 2'b11);
        STALL = 1'b1;
        read(4'd7);
        update(1'b1, 4'd7, 1'b0);
        step();
        check_out("stall1", 1'b0, 2'b01, 4'd2, 1'b1);
        update(1'b0, 4'd0, 1'b0);
        step();
        check_out("stall2", 1'b0, 2'b01, 4'd2, 1'b1);
        STALL = 1'b0;
        read(4'd7);
        step();
        check_out("post_stall7", 1'b1, 2'b11, 4'd7, 1'b1);

        // Reset mid-read, no clock edge; then seen state must be gone.
        read(4'd15);
        step();
        check_out("pre_reset", 1'b1, 2'b11, 4'd15, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        check_out("async_reset", 1'b0, 2'b01, 4'd0, 1'b0);
        #1;
        RESET = 1'b0;
        read(4'd15);
        step();
        check_out("after_reset15", 1'b0, 2'b01, 4'd15, 1'b1);
        read(4'd7);
        step();
        check_out("after_reset7", 1'b0, 2'b01, 4'd7, 1'b1);
        READ_EN = 1'b0;
        step();
        check("final_valid", 32'(VALID), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
